// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared RV32 execute-stage types and constants: divider
//                opcode and state encodings, default datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // op[0] clear selects the signed flavours (DIV, REM)
    function automatic logic div_op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // op[1] set selects the remainder flavours (REM, REMU)
    function automatic logic div_op_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration. Shifts the
//                next dividend bit into the partial remainder and subtracts
//                the divisor; the difference is kept only when non-negative.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    // One extra guard bit above the WIDTH+1 partial remainder carries the
    // borrow, so an unsigned divisor >= 2^(WIDTH-1) never overflows.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Trial subtraction and restore select
    always_comb begin
        shifted  = {rem, dvd_msb};
        diff     = shifted - {2'b00, dvs};
        q_bit    = ~diff[WIDTH+1];
        rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle RV32M DIV/DIVU/REM/REMU unit. Radix-2 restoring
//                division, one quotient bit per clock, with single-edge
//                handling of divide-by-zero and signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import rv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       div_op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int             CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
    localparam logic [1:0]     S_IDLE = DIV_IDLE;
    localparam logic [1:0]     S_CALC = DIV_CALC;
    localparam logic [1:0]     S_DONE = DIV_DONE;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             is_rem;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] result_r;

    logic             op_signed;
    logic             op_rem;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic [WIDTH-1:0] fix_res;

    // Operand decode at accept: magnitudes, signs and special-case results
    always_comb begin
        op_signed   = div_op_signed(div_op);
        op_rem      = div_op_rem(div_op);
        a_neg       = op_signed & inA[WIDTH-1];
        b_neg       = op_signed & inB[WIDTH-1];
        a_mag       = a_neg ? (~inA + 1'b1) : inA;
        b_mag       = b_neg ? (~inB + 1'b1) : inB;
        div_zero    = (inB == '0);
        overflow    = op_signed & (inA == {1'b1, {(WIDTH-1){1'b0}}}) & (inB == '1);
        if (div_zero)
            special_res = op_rem ? inA : '1;
        else
            special_res = op_rem ? '0 : inA;
    end

    div_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .dvs      (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Final quotient/remainder of the last iteration with sign fix-up
    always_comb begin
        q_final = {dvd[WIDTH-2:0], q_bit};
        r_final = rem_next[WIDTH-1:0];
        if (is_rem)
            fix_res = r_neg ? (~r_final + 1'b1) : r_final;
        else
            fix_res = q_neg ? (~q_final + 1'b1) : q_final;
    end

    // FSM, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            is_rem   <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            result_r <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else if (state == S_CALC) begin
            rem   <= rem_next;
            dvd   <= {dvd[WIDTH-2:0], q_bit};
            count <= count + 1'b1;
            if (count == LAST) begin
                result_r <= fix_res;
                state    <= S_DONE;
            end
        end else if (start) begin
            // IDLE or DONE: a new request is accepted
            is_rem <= op_rem;
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
            rem    <= '0;
            dvd    <= a_mag;
            dvs    <= b_mag;
            count  <= '0;
            if (div_zero || overflow) begin
                result_r <= special_res;
                state    <= S_DONE;
            end else begin
                state <= S_CALC;
            end
        end else begin
            state <= S_IDLE;
        end
    end

    assign busy   = (state == S_CALC);
    assign done   = (state == S_DONE);
    assign result = result_r;

endmodule
`default_nettype wire
